// File: rtl/mux.sv
// mux -- parameterised word selector with a registered copy and a sticky
// out-of-range flag.
//
// Parameters
//   BITS     width of each data word (1..1024)
//   WORDS    number of input words (2..256)
//   REG_OUT  0: out is the combinational selection; 1: out is the registered copy
//
// Ports
//   clk        rising-edge clock for the registered paths
//   rst_n      asynchronous active-low reset
//   in         data words; in[0] is the word chosen by sel = 0
//   sel        unsigned word select
//   out        selected word (combinational or registered, see REG_OUT)
//   out_q      registered selection, loaded every rising edge
//   sel_err    high while sel >= WORDS (combinational)
//   sel_err_q  sticky copy of sel_err, cleared only by reset
module mux #(
  parameter int  BITS    = 64,
  parameter int  WORDS   = 4,
  parameter int  REG_OUT = 0,
  localparam int SELW    = (($clog2(WORDS) > 1) ? $clog2(WORDS) : 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] in [0:WORDS-1],
  input  logic [SELW-1:0] sel,
  output logic [BITS-1:0] out,
  output logic [BITS-1:0] out_q,
  output logic            sel_err,
  output logic            sel_err_q
);

  logic [BITS-1:0] val_d;
  logic            sel_err_d;

  // Zero-extend the select before comparing so no sign or truncation effects
  // can hide an out-of-range value.
  function automatic logic sel_out_of_range(input logic [SELW-1:0] s);
    logic [31:0] s_ext;
    s_ext = 32'(s);
    return (s_ext >= 32'(WORDS));
  endfunction

  // Next-word selection and range flag.
  // An unknown sel makes the range test unknown, so the else branch indexes
  // with an unknown value and the result is X rather than quietly word 0.
  always_comb begin
    sel_err   = sel_out_of_range(sel);
    sel_err_d = sel_err_q | sel_err;
    if (sel_err) begin
      val_d = {BITS{1'b0}};
    end else begin
      val_d = in[sel];
    end
  end

  // Registered copy of the selection and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= {BITS{1'b0}};
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= val_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Primary output source chosen at elaboration time.
  if (REG_OUT != 0) begin : g_out_reg
    assign out = out_q;
  end else begin : g_out_comb
    assign out = val_d;
  end

endmodule

// File: tb/tb_mux.sv
// tb_mux -- self-checking bench for mux across several parameter sets:
//   A: 64x4 combinational   B: 5x2 combinational   C: 1x2 combinational
//   D: 8x3 combinational (non power of two)      E: 8x4 registered output
module tb_mux;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Config A
  logic [63:0] a_in [0:3];
  logic [1:0]  a_sel;
  logic [63:0] a_out, a_out_q;
  logic        a_err, a_err_q;
  // Config B
  logic [4:0]  b_in [0:1];
  logic        b_sel;
  logic [4:0]  b_out, b_out_q;
  logic        b_err, b_err_q;
  // Config C
  logic [0:0]  c_in [0:1];
  logic        c_sel;
  logic [0:0]  c_out, c_out_q;
  logic        c_err, c_err_q;
  // Config D
  logic [7:0]  d_in [0:2];
  logic [1:0]  d_sel;
  logic [7:0]  d_out, d_out_q;
  logic        d_err, d_err_q;
  // Config E
  logic [7:0]  e_in [0:3];
  logic [1:0]  e_sel;
  logic [7:0]  e_out, e_out_q;
  logic        e_err, e_err_q;

  mux #(.BITS(64), .WORDS(4), .REG_OUT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .sel(a_sel), .out(a_out),
    .out_q(a_out_q), .sel_err(a_err), .sel_err_q(a_err_q));
  mux #(.BITS(5), .WORDS(2), .REG_OUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .sel(b_sel), .out(b_out),
    .out_q(b_out_q), .sel_err(b_err), .sel_err_q(b_err_q));
  mux #(.BITS(1), .WORDS(2), .REG_OUT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in(c_in), .sel(c_sel), .out(c_out),
    .out_q(c_out_q), .sel_err(c_err), .sel_err_q(c_err_q));
  mux #(.BITS(8), .WORDS(3), .REG_OUT(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in(d_in), .sel(d_sel), .out(d_out),
    .out_q(d_out_q), .sel_err(d_err), .sel_err_q(d_err_q));
  mux #(.BITS(8), .WORDS(4), .REG_OUT(1)) u_e (
    .clk(clk), .rst_n(rst_n), .in(e_in), .sel(e_sel), .out(e_out),
    .out_q(e_out_q), .sel_err(e_err), .sel_err_q(e_err_q));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Drive one config's select, wait a moment, and return its combinational outputs.
  task automatic apply(input int cfg, input int s, output logic [63:0] o, output logic e);
    o = 64'h0;
    e = 1'b0;
    case (cfg)
      0: begin a_sel = 2'(s); #1; o = a_out;      e = a_err; end
      1: begin b_sel = 1'(s); #1; o = 64'(b_out); e = b_err; end
      2: begin c_sel = 1'(s); #1; o = 64'(c_out); e = c_err; end
      3: begin d_sel = 2'(s); #1; o = 64'(d_out); e = d_err; end
      default: begin #1; end
    endcase
  endtask

  typedef struct {
    int          cfg;
    int          sel;
    logic [63:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs [0:11];

  // Reference model state for the registered paths.
  logic [63:0] m_a_q;
  logic [7:0]  m_d_q, m_e_q;
  logic        m_d_err_q;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] o;
    logic        e;
    logic [63:0] exp_a;
    logic [7:0]  exp_d;
    logic        exp_derr;
    int          ds;
    bit          do_rst;

    vecs[0]  = '{cfg: 0, sel: 0, exp_out: 64'h1111111111111111, exp_err: 1'b0};
    vecs[1]  = '{cfg: 0, sel: 1, exp_out: 64'h2222222222222222, exp_err: 1'b0};
    vecs[2]  = '{cfg: 0, sel: 2, exp_out: 64'h3333333333333333, exp_err: 1'b0};
    vecs[3]  = '{cfg: 0, sel: 3, exp_out: 64'h4444444444444444, exp_err: 1'b0};
    vecs[4]  = '{cfg: 1, sel: 0, exp_out: 64'd3,  exp_err: 1'b0};
    vecs[5]  = '{cfg: 1, sel: 1, exp_out: 64'd17, exp_err: 1'b0};
    vecs[6]  = '{cfg: 2, sel: 0, exp_out: 64'd1,  exp_err: 1'b0};
    vecs[7]  = '{cfg: 2, sel: 1, exp_out: 64'd0,  exp_err: 1'b0};
    vecs[8]  = '{cfg: 3, sel: 0, exp_out: 64'hAA, exp_err: 1'b0};
    vecs[9]  = '{cfg: 3, sel: 1, exp_out: 64'hBB, exp_err: 1'b0};
    vecs[10] = '{cfg: 3, sel: 2, exp_out: 64'hCC, exp_err: 1'b0};
    vecs[11] = '{cfg: 3, sel: 3, exp_out: 64'h00, exp_err: 1'b1};

    a_in[0] = 64'h1111111111111111; a_in[1] = 64'h2222222222222222;
    a_in[2] = 64'h3333333333333333; a_in[3] = 64'h4444444444444444;
    b_in[0] = 5'd3;  b_in[1] = 5'd17;
    c_in[0] = 1'b1;  c_in[1] = 1'b0;
    d_in[0] = 8'hAA; d_in[1] = 8'hBB; d_in[2] = 8'hCC;
    e_in[0] = 8'h10; e_in[1] = 8'h20; e_in[2] = 8'h30; e_in[3] = 8'h40;
    a_sel = 2'd0; b_sel = 1'b0; c_sel = 1'b0; d_sel = 2'd0; e_sel = 2'd0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset a_out_q", a_out_q, 64'h0);
    check("reset a_sel_err_q", 64'(a_err_q), 64'h0);
    check("reset d_sel_err_q", 64'(d_err_q), 64'h0);
    check("reset e_out (reg)", 64'(e_out), 64'h0);
    check("reset e_out_q", 64'(e_out_q), 64'h0);

    // Combinational table, applied while reset is held: REG_OUT=0 paths
    // must not depend on reset.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].cfg, vecs[i].sel, o, e);
      check($sformatf("table[%0d] cfg%0d sel%0d out", i, vecs[i].cfg, vecs[i].sel), o, vecs[i].exp_out);
      check($sformatf("table[%0d] cfg%0d sel%0d sel_err", i, vecs[i].cfg, vecs[i].sel), 64'(e), 64'(vecs[i].exp_err));
    end

    // Reset release: first edge loads, then async reset clears immediately.
    @(negedge clk);
    a_sel = 2'd2; d_sel = 2'd0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("a_out_q after first edge", a_out_q, 64'h3333333333333333);
    check("d_sel_err_q no error seen", 64'(d_err_q), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("a_out_q async reset", a_out_q, 64'h0);
    check("e_out async reset", 64'(e_out), 64'h0);
    @(negedge clk) rst_n = 1'b1;

    // Sticky out-of-range flag on the 3-word config.
    d_sel = 2'd3;
    @(posedge clk); #1;
    check("d_sel_err_q set", 64'(d_err_q), 64'h1);
    @(negedge clk) d_sel = 2'd0;
    @(posedge clk);
    @(posedge clk); #1;
    check("d_sel_err_q stays set", 64'(d_err_q), 64'h1);
    check("d_sel_err cleared", 64'(d_err), 64'h0);
    check("d_out back to word0", 64'(d_out), 64'hAA);
    check("d_out_q back to word0", 64'(d_out_q), 64'hAA);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("d_sel_err_q cleared by reset", 64'(d_err_q), 64'h0);
    @(negedge clk) rst_n = 1'b1;

    // Registered output latency.
    e_sel = 2'd0;
    @(posedge clk); #1;
    check("e_out word0 after edge", 64'(e_out), 64'h10);
    @(negedge clk) e_sel = 2'd1;
    #1;
    check("e_out holds before edge", 64'(e_out), 64'h10);
    @(posedge clk); #1;
    check("e_out word1 after edge", 64'(e_out), 64'h20);

    // Randomised phase against a reference model; start from a clean reset.
    @(negedge clk) rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_a_q = 64'h0; m_d_q = 8'h0; m_e_q = 8'h0; m_d_err_q = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) a_in[i] = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) d_in[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) e_in[i] = 8'($urandom);
      a_sel = 2'($urandom_range(0, 3));
      d_sel = 2'($urandom_range(0, 3));
      e_sel = 2'($urandom_range(0, 3));
      do_rst = ($urandom_range(0, 19) == 0);
      #1;
      exp_a    = a_in[int'(a_sel)];
      ds       = int'(d_sel);
      exp_derr = (ds >= 3);
      exp_d    = exp_derr ? 8'h00 : d_in[ds];
      check($sformatf("rand[%0d] a_out", n), a_out, exp_a);
      check($sformatf("rand[%0d] d_out", n), 64'(d_out), 64'(exp_d));
      check($sformatf("rand[%0d] d_sel_err", n), 64'(d_err), 64'(exp_derr));
      if (do_rst) begin
        rst_n = 1'b0;
        #1;
        m_a_q = 64'h0; m_d_q = 8'h0; m_e_q = 8'h0; m_d_err_q = 1'b0;
        check($sformatf("rand[%0d] reset a_out_q", n), a_out_q, m_a_q);
        check($sformatf("rand[%0d] reset d_sel_err_q", n), 64'(d_err_q), 64'(m_d_err_q));
        check($sformatf("rand[%0d] reset e_out", n), 64'(e_out), 64'(m_e_q));
        rst_n = 1'b1;
      end
      @(posedge clk);
      m_a_q     = exp_a;
      m_d_q     = exp_d;
      m_d_err_q = m_d_err_q | exp_derr;
      m_e_q     = e_in[int'(e_sel)];
      #1;
      check($sformatf("rand[%0d] a_out_q", n), a_out_q, m_a_q);
      check($sformatf("rand[%0d] d_out_q", n), 64'(d_out_q), 64'(m_d_q));
      check($sformatf("rand[%0d] d_sel_err_q", n), 64'(d_err_q), 64'(m_d_err_q));
      check($sformatf("rand[%0d] e_out", n), 64'(e_out), 64'(m_e_q));
      check($sformatf("rand[%0d] e_out_q", n), 64'(e_out_q), 64'(m_e_q));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
